// File: rtl/image_buf_scheduler_pkg.sv
// Shared encodings and default geometry for the double-buffered image line store.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package image_buf_scheduler_pkg;

    localparam int DEF_LINES = 20;
    localparam int DEF_AW    = 5;

    // Per-bank ownership: the writer only ever fills a FREE bank, the reader
    // only ever drains a FULL one, so the two sides never touch the same bank.
    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FULL    = 2'd1,
        READING = 2'd2
    } bank_st_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_READ  = 2'd1,
        R_DRAIN = 2'd2
    } rd_st_t;

endpackage

// File: rtl/image_buf_scheduler_line_addr_counter.sv
// Line address counter for the read side of the image buffer.
// Latency: count visible one cycle after en; clr wins over en.
// Backpressure: none; the caller gates en.
// Ports: iCLK/iRSTn clock and async reset, clr sync clear, en increment, cnt current value.
module line_addr_counter
    import image_buf_scheduler_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] cnt
);

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + AW'(1);
        end
    end

endmodule

// File: rtl/image_buf_scheduler.sv
// Ping-pong bank scheduler between the SPI line writer and the image consumer.
// Latency: grant is combinational with the request, read data valid one cycle after oRD_EN.
// Backpressure: writer is held off via oWR_ALLOW when its bank is not FREE; reader stalls on iRD_READY.
// Ports:
//   iCLK, iRSTn, iCLR                 clock, async reset, sync clear
//   iWR_EN, iWR_DONE                  writer line strobe and end-of-image pulse
//   oWR_ALLOW, oWR_BANK, oMEM_WE      writer gating, target bank, gated RAM write enable
//   iRD_REQ, iRD_READY                consumer image request and per-line ready
//   oRD_GNT, oRD_BANK, oRD_EN,
//   oRD_ADDR, oRD_VALID, oRD_LAST     read grant, bank, RAM read enable/address, data valid/last
//   oIMG_CNT, oOVF                    number of FULL banks, sticky dropped-write flag
module image_buf_scheduler
    import image_buf_scheduler_pkg::*;
#(
    parameter int DW    = 20,
    parameter int LINES = DEF_LINES,
    parameter int AW    = DEF_AW
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iCLR,
    input  logic          iWR_EN,
    input  logic          iWR_DONE,
    output logic          oWR_ALLOW,
    output logic          oWR_BANK,
    output logic          oMEM_WE,
    input  logic          iRD_REQ,
    input  logic          iRD_READY,
    output logic          oRD_GNT,
    output logic          oRD_BANK,
    output logic          oRD_EN,
    output logic [AW-1:0] oRD_ADDR,
    output logic          oRD_VALID,
    output logic          oRD_LAST,
    output logic [1:0]    oIMG_CNT,
    output logic          oOVF
);

    // The data width only sizes the attached RAM; this controller never
    // touches line data, so it appears here purely as a sanity guard.
    if (DW < 1) begin : g_dw_invalid
    end

    localparam logic [AW-1:0] LAST_ADDR = AW'(LINES - 1);

    bank_st_t      bank_st  [2];
    bank_st_t      bank_nxt [2];
    rd_st_t        rd_st;
    rd_st_t        rd_nxt;

    logic          wr_bank;
    logic          wr_bank_nxt;
    logic          wr_allow;
    logic          wr_done_ok;
    logic          rd_ptr;
    logic          ovf;
    logic          rd_vld;
    logic          rd_grant;
    logic          rd_en;
    logic          rd_drain;
    logic          last_line;
    logic [AW-1:0] rd_addr;

    assign wr_done_ok  = iWR_DONE & wr_allow;
    assign wr_bank_nxt = wr_done_ok ? ~wr_bank : wr_bank;
    assign last_line   = (rd_addr == LAST_ADDR);

    // Read FSM: grant only when the bank next in written order is FULL, so
    // images always leave in the order they arrived.
    always_comb begin
        rd_nxt   = rd_st;
        rd_grant = 1'b0;
        rd_en    = 1'b0;
        rd_drain = 1'b0;
        case (rd_st)
            R_IDLE: begin
                if (iRD_REQ && (bank_st[rd_ptr] == FULL)) begin
                    rd_grant = 1'b1;
                    rd_nxt   = R_READ;
                end
            end
            R_READ: begin
                rd_en = iRD_READY;
                if (iRD_READY && last_line) begin
                    rd_nxt = R_DRAIN;
                end
            end
            R_DRAIN: begin
                rd_drain = 1'b1;
                rd_nxt   = R_IDLE;
            end
            default: rd_nxt = R_IDLE;
        endcase
    end

    // Writer and reader never target the same bank (FREE vs FULL/READING),
    // so their updates can land in the same cycle without conflict.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_nxt[b] = bank_st[b];
            if (wr_done_ok && (wr_bank == 1'(b))) begin
                bank_nxt[b] = FULL;
            end
            if (rd_grant && (rd_ptr == 1'(b))) begin
                bank_nxt[b] = READING;
            end
            if (rd_drain && (rd_ptr == 1'(b))) begin
                bank_nxt[b] = FREE;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            bank_st[0] <= FREE;
            bank_st[1] <= FREE;
            rd_st      <= R_IDLE;
            wr_bank    <= 1'b0;
            wr_allow   <= 1'b1;
            rd_ptr     <= 1'b0;
            ovf        <= 1'b0;
            rd_vld     <= 1'b0;
        end else if (iCLR) begin
            bank_st[0] <= FREE;
            bank_st[1] <= FREE;
            rd_st      <= R_IDLE;
            wr_bank    <= 1'b0;
            wr_allow   <= 1'b1;
            rd_ptr     <= 1'b0;
            ovf        <= 1'b0;
            rd_vld     <= 1'b0;
        end else begin
            bank_st[0] <= bank_nxt[0];
            bank_st[1] <= bank_nxt[1];
            rd_st      <= rd_nxt;
            wr_bank    <= wr_bank_nxt;
            // Allow is sampled from the registered bank state, so a bank
            // freed by the reader opens the writer one cycle after it
            // shows FREE.
            wr_allow   <= (bank_st[wr_bank_nxt] == FREE);
            if (rd_drain) begin
                rd_ptr <= ~rd_ptr;
            end
            if (iWR_EN && !wr_allow) begin
                ovf <= 1'b1;
            end
            rd_vld     <= rd_en;
        end
    end

    // The final line does not advance the counter, so the address parks at
    // LINES-1 until the next grant resets it.
    line_addr_counter #(
        .AW (AW)
    ) u_addr (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .clr   (iCLR | rd_grant),
        .en    (rd_en & ~last_line),
        .cnt   (rd_addr)
    );

    assign oWR_ALLOW = wr_allow;
    assign oWR_BANK  = wr_bank;
    assign oMEM_WE   = iWR_EN & wr_allow;
    assign oRD_GNT   = rd_grant;
    assign oRD_BANK  = rd_ptr;
    assign oRD_EN    = rd_en;
    assign oRD_ADDR  = rd_addr;
    assign oRD_VALID = rd_vld;
    assign oRD_LAST  = rd_vld & (rd_st == R_DRAIN);
    assign oIMG_CNT  = {1'b0, (bank_st[0] == FULL)} + {1'b0, (bank_st[1] == FULL)};
    assign oOVF      = ovf;

endmodule

// File: tb/tb_image_buf_scheduler.sv
// Scoreboard bench for image_buf_scheduler: expected read addresses are queued
// when a read is requested and consumed as the DUT issues oRD_EN / oRD_VALID.
module tb_image_buf_scheduler;

    localparam int LINES = 20;
    localparam int AW    = 5;

    logic          iCLK = 1'b0;
    logic          iRSTn = 1'b0;
    logic          iCLR = 1'b0;
    logic          iWR_EN = 1'b0;
    logic          iWR_DONE = 1'b0;
    logic          iRD_REQ = 1'b0;
    logic          iRD_READY = 1'b0;
    logic          oWR_ALLOW, oWR_BANK, oMEM_WE;
    logic          oRD_GNT, oRD_BANK, oRD_EN, oRD_VALID, oRD_LAST, oOVF;
    logic [AW-1:0] oRD_ADDR;
    logic [1:0]    oIMG_CNT;

    int total = 0;
    int bad   = 0;
    int gnt_cnt = 0;
    int vld_cnt = 0;
    int last_cnt = 0;
    int exp_q[$];
    int last_q[$];

    always #5 iCLK = ~iCLK;

    image_buf_scheduler #(.DW(20), .LINES(LINES), .AW(AW)) dut (
        .iCLK      (iCLK),
        .iRSTn     (iRSTn),
        .iCLR      (iCLR),
        .iWR_EN    (iWR_EN),
        .iWR_DONE  (iWR_DONE),
        .oWR_ALLOW (oWR_ALLOW),
        .oWR_BANK  (oWR_BANK),
        .oMEM_WE   (oMEM_WE),
        .iRD_REQ   (iRD_REQ),
        .iRD_READY (iRD_READY),
        .oRD_GNT   (oRD_GNT),
        .oRD_BANK  (oRD_BANK),
        .oRD_EN    (oRD_EN),
        .oRD_ADDR  (oRD_ADDR),
        .oRD_VALID (oRD_VALID),
        .oRD_LAST  (oRD_LAST),
        .oIMG_CNT  (oIMG_CNT),
        .oOVF      (oOVF)
    );

    task automatic chk(input string tag, input int obs, input int want);
        total++;
        if (obs != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, want, $time);
        end
    endtask

    // Read-side monitor: every oRD_EN must match the next queued address,
    // every oRD_VALID must match a preceding oRD_EN, last only on line LINES-1.
    always @(negedge iCLK) begin
        int e;
        if (oRD_GNT) gnt_cnt++;
        if (oRD_EN) begin
            if (exp_q.size() == 0) begin
                chk("rd_en_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_addr", int'(oRD_ADDR), e);
                last_q.push_back(e == LINES - 1);
            end
        end
        if (oRD_VALID) begin
            vld_cnt++;
            if (last_q.size() == 0) chk("rd_valid_unexpected", 1, 0);
            else chk("rd_last", int'(oRD_LAST), last_q.pop_front());
        end else if (oRD_LAST) begin
            chk("last_without_valid", 1, 0);
        end
        if (oRD_LAST) last_cnt++;
    end

    task automatic do_reset();
        @(posedge iCLK); #1;
        iRSTn = 1'b0; iCLR = 1'b0; iWR_EN = 1'b0; iWR_DONE = 1'b0;
        iRD_REQ = 1'b0; iRD_READY = 1'b0;
        exp_q.delete(); last_q.delete();
        repeat (3) @(posedge iCLK);
        #1 iRSTn = 1'b1;
    endtask

    task automatic write_lines(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iCLK); #1;
            iWR_EN = 1'b1;
            if (i == 0) begin
                @(negedge iCLK);
                chk("mem_we_writing", int'(oMEM_WE), 1);
            end
        end
        @(posedge iCLK); #1;
        iWR_EN = 1'b0;
    endtask

    task automatic write_image();
        write_lines(LINES);
        iWR_DONE = 1'b1;
        @(posedge iCLK); #1;
        iWR_DONE = 1'b0;
    endtask

    // Requests one image and waits for oRD_LAST; returns at the negedge of
    // the cycle after the drain (bank freed and read pointer toggled).
    task automatic read_image(input bit toggle, input int bank);
        int  g0 = gnt_cnt;
        int  v0 = vld_cnt;
        int  cyc = 0;
        bit  seen_last = 1'b0;
        for (int i = 0; i < LINES; i++) exp_q.push_back(i);
        @(posedge iCLK); #1;
        iRD_REQ = 1'b1;
        iRD_READY = 1'b1;
        @(negedge iCLK);
        chk("rd_gnt", int'(oRD_GNT), 1);
        chk("rd_bank_at_gnt", int'(oRD_BANK), bank);
        chk("rd_addr_at_gnt", int'(oRD_ADDR), 0);
        while (!seen_last && cyc < 200) begin
            @(posedge iCLK); #1;
            iRD_REQ = toggle;
            iRD_READY = toggle ? ((cyc % 2) == 0) : 1'b1;
            cyc++;
            @(negedge iCLK);
            if (!iRD_READY) chk("rd_en_without_ready", int'(oRD_EN), 0);
            if (oRD_LAST) seen_last = 1'b1;
        end
        chk("read_completed", int'(seen_last), 1);
        @(posedge iCLK); #1;
        iRD_REQ = 1'b0;
        iRD_READY = 1'b0;
        @(negedge iCLK);
        chk("valid_pulses", vld_cnt - v0, LINES);
        chk("grant_pulses", gnt_cnt - g0, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int l0;
        int v0;
        bit found;

        // Reset state
        do_reset();
        @(negedge iCLK);
        chk("rst_wr_allow", int'(oWR_ALLOW), 1);
        chk("rst_wr_bank", int'(oWR_BANK), 0);
        chk("rst_img_cnt", int'(oIMG_CNT), 0);
        chk("rst_ovf", int'(oOVF), 0);
        chk("rst_rd_valid", int'(oRD_VALID), 0);
        chk("rst_rd_addr", int'(oRD_ADDR), 0);

        // One image into bank 0
        write_image();
        @(negedge iCLK);
        chk("img1_cnt", int'(oIMG_CNT), 1);
        chk("img1_wr_bank", int'(oWR_BANK), 1);
        chk("img1_wr_allow", int'(oWR_ALLOW), 1);

        // Full-speed read of bank 0
        read_image(1'b0, 0);
        chk("read1_img_cnt", int'(oIMG_CNT), 0);
        chk("read1_rd_bank", int'(oRD_BANK), 1);

        // Fill both banks, then overflow and an ignored done
        do_reset();
        @(negedge iCLK);
        chk("rst2_ovf", int'(oOVF), 0);
        write_image();
        write_image();
        @(negedge iCLK);
        chk("full_img_cnt", int'(oIMG_CNT), 2);
        chk("full_wr_allow", int'(oWR_ALLOW), 0);
        chk("full_wr_bank", int'(oWR_BANK), 0);
        @(posedge iCLK); #1;
        iWR_EN = 1'b1;
        @(negedge iCLK);
        chk("ovf_mem_we", int'(oMEM_WE), 0);
        @(posedge iCLK); #1;
        iWR_EN = 1'b0;
        @(negedge iCLK);
        chk("ovf_set", int'(oOVF), 1);
        @(posedge iCLK); #1;
        iWR_DONE = 1'b1;
        @(posedge iCLK); #1;
        iWR_DONE = 1'b0;
        @(negedge iCLK);
        chk("ignored_done_bank", int'(oWR_BANK), 0);
        chk("ignored_done_cnt", int'(oIMG_CNT), 2);
        chk("ovf_held", int'(oOVF), 1);

        // Stalled read of bank 0 with request held; writer unblocks a cycle after FREE
        read_image(1'b1, 0);
        chk("unblock_img_cnt", int'(oIMG_CNT), 1);
        chk("unblock_allow_early", int'(oWR_ALLOW), 0);
        @(negedge iCLK);
        chk("unblock_allow", int'(oWR_ALLOW), 1);
        chk("unblock_wr_bank", int'(oWR_BANK), 0);
        chk("ovf_still_held", int'(oOVF), 1);

        // Done and grant in the same cycle, then clear mid-read at line 7
        write_lines(LINES);
        for (int i = 0; i < LINES; i++) exp_q.push_back(i);
        iWR_DONE = 1'b1;
        iRD_REQ = 1'b1;
        iRD_READY = 1'b1;
        @(negedge iCLK);
        chk("sim_gnt", int'(oRD_GNT), 1);
        chk("sim_rd_bank", int'(oRD_BANK), 1);
        @(posedge iCLK); #1;
        iWR_DONE = 1'b0;
        iRD_REQ = 1'b0;
        @(negedge iCLK);
        chk("sim_img_cnt", int'(oIMG_CNT), 1);
        chk("sim_wr_bank", int'(oWR_BANK), 1);
        chk("sim_wr_allow", int'(oWR_ALLOW), 0);
        l0 = last_cnt;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge iCLK); #1;
            if (oRD_ADDR == AW'(7)) begin
                iCLR = 1'b1;
                found = 1'b1;
            end
        end
        chk("clr_point_reached", int'(found), 1);
        @(posedge iCLK); #1;
        iCLR = 1'b0;
        exp_q.delete();
        last_q.delete();
        @(negedge iCLK);
        v0 = vld_cnt;
        chk("clr_wr_allow", int'(oWR_ALLOW), 1);
        chk("clr_wr_bank", int'(oWR_BANK), 0);
        chk("clr_rd_bank", int'(oRD_BANK), 0);
        chk("clr_rd_addr", int'(oRD_ADDR), 0);
        chk("clr_rd_en", int'(oRD_EN), 0);
        chk("clr_rd_valid", int'(oRD_VALID), 0);
        chk("clr_rd_last", int'(oRD_LAST), 0);
        chk("clr_rd_gnt", int'(oRD_GNT), 0);
        chk("clr_img_cnt", int'(oIMG_CNT), 0);
        chk("clr_ovf", int'(oOVF), 0);
        repeat (5) @(negedge iCLK);
        chk("clr_no_valid_after", vld_cnt - v0, 0);
        chk("clr_no_last", last_cnt - l0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/image_buf_scheduler.md
IMAGE_BUF_SCHEDULER -- requirements
Module: image_buf_scheduler

Interface
REQ-001 Parameter DW, default 20, line data width in bits; carried for documentation and port sizing of the attached RAM only.
REQ-002 Parameter LINES, default 20, lines per image.
REQ-003 Parameter AW, default 5, line address width.
REQ-004 iCLK  in  1  system clock, rising edge.
REQ-005 iRSTn  in  1  asynchronous active-low reset.
REQ-006 iCLR  in  1  synchronous clear, same effect as reset.
REQ-007 iWR_EN  in  1  line-write strobe from the SPI write controller.
REQ-008 iWR_DONE  in  1  single-cycle pulse, current image fully written.
REQ-009 oWR_ALLOW  out  1  writer may accept SPI data; gates the write controller enable.
REQ-010 oWR_BANK  out  1  bank the writer targets; RAM write address MSB.
REQ-011 oMEM_WE  out  1  gated RAM write enable.
REQ-012 iRD_REQ  in  1  consumer (STFT/CNN engine) requests an image.
REQ-013 iRD_READY  in  1  consumer can accept a line this cycle.
REQ-014 oRD_GNT  out  1  single-cycle pulse, read of one image starts.
REQ-015 oRD_BANK  out  1  bank being read.
REQ-016 oRD_EN  out  1  RAM read enable.
REQ-017 oRD_ADDR  out  AW  RAM read line address.
REQ-018 oRD_VALID  out  1  RAM read data valid, one cycle after oRD_EN.
REQ-019 oRD_LAST  out  1  asserted with oRD_VALID of line LINES-1.
REQ-020 oIMG_CNT  out  2  number of banks in FULL state, 0..2.
REQ-021 oOVF  out  1  sticky overflow flag.

Function
REQ-022 Two banks, each with state FREE, FULL or READING.
REQ-023 Combinational oMEM_WE = iWR_EN AND oWR_ALLOW.
REQ-024 iWR_EN while oWR_ALLOW=0: write dropped; oOVF set next cycle; oOVF held until reset/iCLR.
REQ-025 iWR_DONE with oWR_ALLOW=1:
- bank oWR_BANK goes FULL next cycle
- oWR_BANK toggles next cycle
- oWR_ALLOW next cycle = (new target bank is FREE)
REQ-026 iWR_DONE while oWR_ALLOW=0: ignored.
REQ-027 oWR_ALLOW rises the cycle after its target bank becomes FREE.
REQ-028 Read FSM states R_IDLE, R_READ, R_DRAIN.
REQ-029 R_IDLE -> R_READ when iRD_REQ=1 and bank rd_ptr is FULL:
- oRD_GNT pulses in that cycle
- bank rd_ptr becomes READING next cycle
- oRD_ADDR = 0
REQ-030 rd_ptr drives oRD_BANK; it toggles only on image read completion, so images are read in written order.
REQ-031 In R_READ, oRD_EN = iRD_READY; each oRD_EN cycle increments oRD_ADDR by 1.
REQ-032 R_READ -> R_DRAIN on oRD_EN with oRD_ADDR=LINES-1.
REQ-033 In R_DRAIN:
- oRD_VALID and oRD_LAST asserted for one cycle
- bank rd_ptr set FREE next cycle, rd_ptr toggles
- FSM -> R_IDLE
REQ-034 oRD_VALID is oRD_EN registered one cycle; no other latency.
REQ-035 iRD_READY=0 holds oRD_ADDR with no timeout.
REQ-036 Simultaneous bank FREE (read completion) and writer blocked on that bank: oWR_ALLOW=1 exactly one cycle later.
REQ-037 Simultaneous iWR_DONE and read-side state change on the other bank: both take effect in the same cycle.
REQ-038 oIMG_CNT is combinational from the bank states.
REQ-039 iRD_REQ held in R_READ/R_DRAIN has no effect.
REQ-040 oRD_ADDR does not wrap past LINES-1; it returns to 0 only via the R_IDLE grant.

Reset
REQ-041 On iRSTn=0 or iCLR=1:
- both banks FREE
- oWR_BANK=0, rd_ptr=0
- read FSM R_IDLE, oRD_ADDR=0
- oOVF=0, oRD_GNT=oRD_EN=oRD_VALID=oRD_LAST=0
- oWR_ALLOW=1
REQ-042 iCLR during R_READ aborts the read: no oRD_LAST, no further oRD_VALID after the clear cycle.

Structure
REQ-043 Shared package holds:
- bank-state encoding (FREE=2'd0, FULL=2'd1, READING=2'd2)
- read FSM encoding
- LINES and AW defaults
REQ-044 One sub-module, line_addr_counter: AW-bit counter with enable and synchronous clear, used for oRD_ADDR.

Verification
REQ-045 Reset, write 20 lines + iWR_DONE -> oIMG_CNT=1, oWR_BANK=1, oWR_ALLOW=1.
REQ-046 After REQ-045, iRD_REQ with iRD_READY=1:
- oRD_GNT one cycle
- oRD_ADDR 0..19 on consecutive cycles
- 20 oRD_VALID, oRD_LAST on the 20th
- bank0 FREE afterwards, oIMG_CNT=0
REQ-047 Fill both banks with no read -> oWR_ALLOW=0; one extra iWR_EN -> oMEM_WE=0, oOVF=1 and held.
REQ-048 Both banks full, complete a read of bank0 -> oWR_ALLOW=1 one cycle after bank0 FREE, oWR_BANK=0.
REQ-049 Toggle iRD_READY 1,0,1,0 during a read -> oRD_ADDR advances only on READY cycles; exactly 20 oRD_VALID pulses.
REQ-050 iCLR at oRD_ADDR=7 -> next cycle:
- all outputs at reset values
- oRD_LAST never asserted
- oIMG_CNT=0
